lfsr_rr_ctrl: RTL and testbench

//  Shares one 10-bit PRNG engine (x^10+x^7+1, right-shift, feedback into MSB) among N_REQ requesters.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/rr_arb_n.sv | 30 +++
 rtl/lfsr_rr_ctrl.sv | 130 +++++++++++++
 tb/tb_lfsr_rr_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the arbitrated LFSR random source: width, tap,
// FSM encoding and the single-step shift function.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned TAP    = 7;

  localparam logic [LFSR_W-1:0] SAFE_SEED = 10'h001;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // x^10 + x^7 + 1, right shift with feedback into the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[TAP] ^ s[0], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after the last winner, with wrap-around.
module rr_arb_n #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = IDX_W'((32'(last) + k) % N_REQ);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/lfsr_rr_ctrl.sv
// One shared 10-bit LFSR served to N_REQ requesters in round-robin order;
// each grant runs STEPS shifts and returns the word with a valid/ack handshake.
module lfsr_rr_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned       N_REQ = 2,
  parameter logic [LFSR_W-1:0] SEED  = 10'h001,
  parameter int unsigned       STEPS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              ack_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [LFSR_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (STEPS < 1 || STEPS > 15) begin : g_bad_steps
    $error("lfsr_rr_ctrl: STEPS must be in 1..15");
  end
  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
    $error("lfsr_rr_ctrl: N_REQ must be in 2..4");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rr_ctrl: SEED must be nonzero");
  end

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] data_q, data_d;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arb_n #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req  (req_i),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign lfsr_nxt = lfsr_step(lfsr_q);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        // A zero seed would lock the register up, so substitute the safe seed.
        if (seed_we_i) begin
          lfsr_d = (seed_i == '0) ? SAFE_SEED : seed_i;
        end
        if (arb_any) begin
          gnt_d   = arb_gnt;
          win_d   = arb_idx;
          cnt_d   = 4'(STEPS);
          state_d = StRun;
        end
      end
      StRun: begin
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = lfsr_nxt;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ack_i) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      data_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// Bench for lfsr_rr_ctrl: directed vectors on a STEPS=10 and a STEPS=1
// instance, then randomized transactions on the STEPS=1 instance against a model.
module tb_lfsr_rr_ctrl;

  localparam int unsigned STEPS_A = 10;
  localparam int unsigned STEPS_B = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       seed_we_a = 1'b0, seed_we_b = 1'b0;
  logic [9:0] seed_a = '0, seed_b = '0;
  logic [1:0] req_a = '0, req_b = '0;
  logic       ack_a = 1'b0, ack_b = 1'b0;
  logic [1:0] gnt_a, gnt_b;
  logic [9:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  int n_checks = 0;
  int n_err = 0;
  int m_lfsr = 1;
  int m_last = 1;

  always #5 clk = ~clk;

  lfsr_rr_ctrl #(.N_REQ(2), .SEED(10'h001), .STEPS(STEPS_A)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_we_i (seed_we_a),
    .seed_i    (seed_a),
    .req_i     (req_a),
    .ack_i     (ack_a),
    .gnt_o     (gnt_a),
    .data_o    (data_a),
    .valid_o   (valid_a),
    .busy_o    (busy_a)
  );

  lfsr_rr_ctrl #(.N_REQ(2), .SEED(10'h001), .STEPS(STEPS_B)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_we_i (seed_we_b),
    .seed_i    (seed_b),
    .req_i     (req_b),
    .ack_i     (ack_b),
    .gnt_o     (gnt_b),
    .data_o    (data_b),
    .valid_o   (valid_b),
    .busy_o    (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: feedback bit is bit7 xor bit0, shifted in at bit 9.
  function automatic int ref_step(input int s);
    int fb;
    fb = ((s >> 7) ^ s) & 1;
    return ((s >> 1) | (fb << 9)) & 'h3FF;
  endfunction

  function automatic int ref_winner(input int req, input int last);
    for (int k = 1; k <= 2; k++) begin
      int j;
      j = (last + k) % 2;
      if (((req >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    seed_we_a = 0; seed_a = '0; req_a = '0; ack_a = 0;
    seed_we_b = 0; seed_b = '0; req_b = '0; ack_b = 0;
    rst_n = 0;
    #2;
    chk("rst_gnt", 32'(gnt_b), 0);
    chk("rst_valid", 32'(valid_b), 0);
    chk("rst_busy", 32'(busy_b), 0);
    chk("rst_data", 32'(data_b), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_lfsr = 1;
    m_last = 1;
  endtask

  // One full transaction on dut_b, starting and ending with the DUT in IDLE.
  task automatic txn_b(input logic [1:0] req, input bit sw, input logic [9:0] sd,
                       input int ack_dly, input bit noise, input bit drop,
                       output logic [9:0] got);
    int win;
    int cyc;
    int exp_d;
    got = data_b;
    req_b = req;
    seed_we_b = sw;
    seed_b = sd;
    if (sw) m_lfsr = (sd == 0) ? 1 : int'(sd);
    win = ref_winner(int'(req), m_last);
    clk_step();
    seed_we_b = 0;
    if (win < 0) begin
      chk("idle_gnt", 32'(gnt_b), 0);
      chk("idle_busy", 32'(busy_b), 0);
      return;
    end
    chk("gnt", 32'(gnt_b), 32'(1 << win));
    chk("busy_run", 32'(busy_b), 1);
    if (drop) req_b = '0;
    if (noise) begin
      seed_we_b = 1;
      seed_b = 10'($urandom);
      ack_b = 1;
    end
    exp_d = m_lfsr;
    for (int i = 0; i < int'(STEPS_B); i++) exp_d = ref_step(exp_d);
    m_lfsr = exp_d;
    cyc = 0;
    while (!valid_b && cyc < 40) begin
      clk_step();
      cyc++;
    end
    seed_we_b = 0;
    ack_b = 0;
    chk("latency", 32'(cyc), STEPS_B);
    chk("data", 32'(data_b), 32'(exp_d));
    got = data_b;
    repeat (ack_dly) clk_step();
    chk("valid_hold", 32'(valid_b), 1);
    chk("gnt_hold", 32'(gnt_b), 32'(1 << win));
    ack_b = 1;
    clk_step();
    ack_b = 0;
    chk("valid_clr", 32'(valid_b), 0);
    chk("gnt_clr", 32'(gnt_b), 0);
    chk("busy_clr", 32'(busy_b), 0);
    chk("data_keep", 32'(data_b), 32'(exp_d));
    m_last = win;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    logic [9:0] seq4 [4];
    int cyc;
    seq4[0] = 10'h200; seq4[1] = 10'h100; seq4[2] = 10'h080; seq4[3] = 10'h240;

    reset_dut();

    // STEPS=10 instance: exact latency and the 10-shift word from the reset seed.
    req_a = 2'b01;
    clk_step();
    req_a = '0;
    chk("a_gnt", 32'(gnt_a), 1);
    for (int i = 0; i < int'(STEPS_A) - 1; i++) begin
      clk_step();
      chk("a_valid_early", 32'(valid_a), 0);
    end
    clk_step();
    chk("a_valid", 32'(valid_a), 1);
    chk("a_data", 32'(data_a), 'h249);
    ack_a = 1;
    clk_step();
    ack_a = 0;
    chk("a_valid_clr", 32'(valid_a), 0);
    chk("a_gnt_clr", 32'(gnt_a), 0);

    // Reset in the middle of RUN, then restart from SEED with requester 0 first.
    req_a = 2'b11;
    clk_step();
    chk("a_gnt_rr", 32'(gnt_a), 2);
    repeat (3) clk_step();
    rst_n = 0;
    #1;
    chk("a_rst_gnt", 32'(gnt_a), 0);
    chk("a_rst_valid", 32'(valid_a), 0);
    chk("a_rst_busy", 32'(busy_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_lfsr = 1;
    m_last = 1;
    clk_step();
    chk("a_gnt_after_rst", 32'(gnt_a), 1);
    cyc = 0;
    while (!valid_a && cyc < 40) begin
      clk_step();
      cyc++;
    end
    req_a = '0;
    chk("a_latency_after_rst", 32'(cyc), STEPS_A);
    chk("a_data_after_rst", 32'(data_a), 'h249);
    ack_a = 1;
    clk_step();
    ack_a = 0;

    // STEPS=1 directed vectors.
    txn_b(2'b01, 0, '0, 1, 0, 0, got);
    chk("b_first", 32'(got), 'h200);
    txn_b(2'b01, 0, '0, 0, 0, 0, got);
    chk("b_second", 32'(got), 'h100);

    reset_dut();
    for (int i = 0; i < 4; i++) begin
      txn_b(2'b11, 0, '0, 0, 0, 0, got);
      chk("b_alt_data", 32'(got), 32'(seq4[i]));
    end
    req_b = '0;

    txn_b(2'b01, 1, 10'h000, 0, 0, 0, got);
    chk("b_zero_seed", 32'(got), 'h200);

    txn_b(2'b10, 0, '0, 2, 1, 1, got);

    // Randomized transactions.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] r;
      logic [9:0] sd;
      r = 2'($urandom_range(0, 3));
      sd = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
      txn_b(r, ($urandom_range(0, 3) == 0), sd, int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
